// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE/FETCH/SETTLE/ISSUE/EXEC/HALT control with PC, branch redirect and halt limit.
// Optional FETCH_SEQ_PERF_CNT_EN adds a saturating retired-instruction counter on retired_cnt.
module fetch_sequencer #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] PC_LIMIT = 16'h00FF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stall,
   input  logic        exec_done,
   input  logic        branch_taken,
   input  logic [11:0] branch_target,
   output logic [15:0] address,
   output logic        im_select,
   output logic        issue_valid,
   output logic        busy,
   output logic        halted
`ifdef FETCH_SEQ_PERF_CNT_EN
   ,
   output logic [31:0] retired_cnt
`endif
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      SETTLE = 3'd2,
      ISSUE  = 3'd3,
      EXEC   = 3'd4,
      HALT   = 3'd5
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        accept;
   logic [15:0] pc_next;
   logic        pc_over;

   // exec_done is only honoured in EXEC and while not stalled
   always_comb begin
      accept  = (state == EXEC) && exec_done && !stall;
      pc_next = branch_taken ? {4'b0, branch_target} : address + 16'd1;
      pc_over = pc_next > PC_LIMIT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!stall) begin
         case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   state_nxt = SETTLE;
            SETTLE:  state_nxt = ISSUE;
            ISSUE:   state_nxt = EXEC;
            EXEC:    if (accept) state_nxt = pc_over ? HALT : FETCH;
            HALT:    if (start) state_nxt = FETCH;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         address   <= RESET_PC;
         im_select <= 1'b0;
      end else if (!stall) begin
         if (state == FETCH) im_select <= ~im_select;
         if (accept && !pc_over) address <= pc_next;
         if (state == HALT && start) address <= RESET_PC;
      end
   end

   always_comb begin
      issue_valid = (state == ISSUE) && !stall;
      busy        = (state != IDLE) && (state != HALT);
      halted      = (state == HALT);
   end

`ifdef FETCH_SEQ_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          retired_cnt <= '0;
      else if (accept && retired_cnt != '1) retired_cnt <= retired_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer (PC_LIMIT=7): sequencing, branch, stall, halt, restart, async reset.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic        exec_done = 1'b0;
   logic        branch_taken = 1'b0;
   logic [11:0] branch_target = '0;
   logic [15:0] address;
   logic        im_select;
   logic        issue_valid;
   logic        busy;
   logic        halted;
`ifdef FETCH_SEQ_PERF_CNT_EN
   logic [31:0] retired_cnt;
`endif

   int total = 0;
   int bad   = 0;
   logic exp_im = 1'b0;
   int   n_ret  = 0;

   fetch_sequencer #(.RESET_PC(16'h0000), .PC_LIMIT(16'h0007)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
      .exec_done(exec_done), .branch_taken(branch_taken), .branch_target(branch_target),
      .address(address), .im_select(im_select), .issue_valid(issue_valid),
      .busy(busy), .halted(halted)
`ifdef FETCH_SEQ_PERF_CNT_EN
      , .retired_cnt(retired_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

`ifdef FETCH_SEQ_PERF_CNT_EN
   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
`endif

   // One instruction: wait for issue, check it, retire it 3 cycles after issue, check the redirect.
   task automatic do_instr(input logic [15:0] exp_addr, input logic br, input logic [11:0] tgt,
                           input logic [15:0] exp_next, input logic halt_exp, input logic mask);
      for (int i = 0; i < 8; i++) begin
         if (issue_valid) break;
         tick();
      end
      chk1("issue_seen", issue_valid, 1'b1);
      chk16("issue_addr", address, exp_addr);
      chk1("issue_im", im_select, exp_im);
      tick();
      chk1("iv_one_cycle", issue_valid, 1'b0);
      if (mask) begin
         stall = 1'b1;
         exec_done = 1'b1;
         tick();
         exec_done = 1'b0;
         stall = 1'b0;
         chk16("masked_done_addr", address, exp_addr);
         tick();
         chk1("masked_done_busy", busy, 1'b1);
         chk16("masked_done_addr2", address, exp_addr);
      end else begin
         tick();
      end
      exec_done = 1'b1;
      branch_taken = br;
      branch_target = tgt;
      tick();
      exec_done = 1'b0;
      branch_taken = 1'b0;
      n_ret++;
      if (halt_exp) begin
         chk1("halted", halted, 1'b1);
         chk1("halt_busy", busy, 1'b0);
         chk16("halt_addr", address, exp_addr);
         for (int i = 0; i < 3; i++) tick();
         chk1("halt_no_toggle", im_select, exp_im);
         chk16("halt_addr_hold", address, exp_addr);
      end else begin
         chk16("next_addr", address, exp_next);
         chk1("no_toggle_yet", im_select, exp_im);
         tick();
         exp_im = ~exp_im;
         chk1("fetch_toggle", im_select, exp_im);
      end
   endtask

   initial begin
      #12;
      chk16("rst_addr", address, 16'h0000);
      chk1("rst_im", im_select, 1'b0);
      chk1("rst_iv", issue_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_halted", halted, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      chk1("idle_stays", busy, 1'b0);

      start = 1'b1;
      tick();
      start = 1'b0;
      chk1("fetch_busy", busy, 1'b1);
      chk1("first_no_early_toggle", im_select, 1'b0);
      tick();
      exp_im = ~exp_im;
      chk1("first_toggle", im_select, exp_im);
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      chk1("done_outside_exec_iv", issue_valid, 1'b1);
      chk16("done_outside_exec_addr", address, 16'h0000);

      do_instr(16'h0000, 1'b0, 12'h000, 16'h0001, 1'b0, 1'b0);

      tick();
      chk1("iv_before_stall", issue_valid, 1'b1);
      stall = 1'b1;
      #1;
      chk1("stall_iv_low", issue_valid, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk1("stall_iv_hold", issue_valid, 1'b0);
         chk16("stall_addr", address, 16'h0001);
      end
      stall = 1'b0;
      #1;
      chk1("stall_release_iv", issue_valid, 1'b1);
      do_instr(16'h0001, 1'b0, 12'h000, 16'h0002, 1'b0, 1'b0);
      do_instr(16'h0002, 1'b0, 12'h000, 16'h0003, 1'b0, 1'b1);
      do_instr(16'h0003, 1'b0, 12'h000, 16'h0004, 1'b0, 1'b0);
      do_instr(16'h0004, 1'b0, 12'h000, 16'h0005, 1'b0, 1'b0);
      do_instr(16'h0005, 1'b1, 12'h003, 16'h0003, 1'b0, 1'b0);
      do_instr(16'h0003, 1'b0, 12'h000, 16'h0004, 1'b0, 1'b0);
      do_instr(16'h0004, 1'b0, 12'h000, 16'h0005, 1'b0, 1'b0);
      do_instr(16'h0005, 1'b0, 12'h000, 16'h0006, 1'b0, 1'b0);
      do_instr(16'h0006, 1'b0, 12'h000, 16'h0007, 1'b0, 1'b0);
      do_instr(16'h0007, 1'b0, 12'h000, 16'h0007, 1'b1, 1'b0);
`ifdef FETCH_SEQ_PERF_CNT_EN
      chk32("retired_cnt", retired_cnt, 32'(n_ret));
`endif

      start = 1'b1;
      tick();
      start = 1'b0;
      chk16("restart_addr", address, 16'h0000);
      chk1("restart_halted", halted, 1'b0);
      tick();
      exp_im = ~exp_im;
      chk1("restart_toggle", im_select, exp_im);
      do_instr(16'h0000, 1'b0, 12'h000, 16'h0001, 1'b0, 1'b0);
      do_instr(16'h0001, 1'b0, 12'h000, 16'h0002, 1'b0, 1'b0);
      do_instr(16'h0002, 1'b0, 12'h000, 16'h0003, 1'b0, 1'b0);
      do_instr(16'h0003, 1'b0, 12'h000, 16'h0004, 1'b0, 1'b0);

      tick();
      chk1("pre_reset_iv", issue_valid, 1'b1);
      chk16("pre_reset_addr", address, 16'h0004);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk16("async_rst_addr", address, 16'h0000);
      chk1("async_rst_iv", issue_valid, 1'b0);
      chk1("async_rst_busy", busy, 1'b0);
      chk1("async_rst_im", im_select, 1'b0);
`ifdef FETCH_SEQ_PERF_CNT_EN
      chk32("async_rst_cnt", retired_cnt, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk1("post_rst_no_early_toggle", im_select, 1'b0);
      tick();
      chk1("post_rst_toggle", im_select, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
